// File: rtl/stage_if.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory port and
// presents {instr, next_pc, valid} to ID with stall hold and delayed-branch redirect.
module stage_if #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_dest,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] if2id_instr,
   output logic [31:0] if2id_next_pc,
   output logic        if2id_valid
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] HELD = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] npc_q, npc_d;
   logic        valid_q, valid_d;
   logic [31:0] skid_q, skid_d;
   logic        redir_q, redir_d;
   logic        owed_q, owed_d;
   logic [31:0] target_q, target_d;

   logic        slot_free, pend, owed, squash, deliver;
   logic [31:0] tgt, seq_addr, del_word;

   always_comb begin
      slot_free = !stall || !valid_q;
      // A new branch counts as pending this very edge; its delay slot is still
      // owed only if ID held no valid word when the branch was sampled.
      pend      = redir_q || branch_taken;
      owed      = redir_q ? owed_q : !valid_q;
      tgt       = branch_taken ? (branch_dest & 32'hFFFF_FFFC) : target_q;
      squash    = pend && !owed;
      seq_addr  = addr_q + 32'd4;

      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      req_d    = req_q;
      instr_d  = instr_q;
      npc_d    = npc_q;
      valid_d  = valid_q;
      skid_d   = skid_q;
      redir_d  = pend;
      owed_d   = owed;
      target_d = tgt;
      deliver  = 1'b0;
      del_word = skid_q;

      case (state_q)
         IDLE: begin
            if (slot_free) begin
               req_d   = 1'b1;
               state_d = WAIT;
               if (squash) begin
                  addr_d  = tgt;
                  redir_d = 1'b0;
               end else begin
                  addr_d = pc_q;
               end
            end
         end
         WAIT: begin
            if (imem_ack) begin
               if (squash) begin
                  addr_d  = tgt;
                  redir_d = 1'b0;
               end else if (slot_free) begin
                  deliver  = 1'b1;
                  del_word = imem_data;
                  addr_d   = seq_addr;
               end else begin
                  skid_d  = imem_data;
                  req_d   = 1'b0;
                  state_d = HELD;
               end
            end
         end
         HELD: begin
            // imem_addr still holds the skid word's address while parked here.
            if (squash) begin
               addr_d  = tgt;
               req_d   = 1'b1;
               redir_d = 1'b0;
               state_d = WAIT;
            end else if (slot_free) begin
               deliver = 1'b1;
               addr_d  = seq_addr;
               req_d   = 1'b1;
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase

      if (deliver) begin
         instr_d = del_word;
         npc_d   = seq_addr;
         valid_d = 1'b1;
         pc_d    = seq_addr;
         owed_d  = 1'b0;
      end else if (slot_free) begin
         valid_d = 1'b0;
         instr_d = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         req_q    <= 1'b0;
         instr_q  <= 32'd0;
         npc_q    <= 32'd0;
         valid_q  <= 1'b0;
         skid_q   <= 32'd0;
         redir_q  <= 1'b0;
         owed_q   <= 1'b0;
         target_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         req_q    <= req_d;
         instr_q  <= instr_d;
         npc_q    <= npc_d;
         valid_q  <= valid_d;
         skid_q   <= skid_d;
         redir_q  <= redir_d;
         owed_q   <= owed_d;
         target_q <= target_d;
      end
   end

   assign imem_addr     = addr_q;
   assign imem_req      = req_q;
   assign if2id_instr   = instr_q;
   assign if2id_next_pc = npc_q;
   assign if2id_valid   = valid_q;
endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: an ID-side stream model (program order plus delayed-branch
// rule) checked every cycle, directed literal checks, then randomized traffic.
module tb_stage_if;
   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_dest = 32'd0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = 32'd0;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] if2id_instr;
   logic [31:0] if2id_next_pc;
   logic        if2id_valid;

   stage_if #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_dest(branch_dest), .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_ack(imem_ack), .imem_data(imem_data), .if2id_instr(if2id_instr),
      .if2id_next_pc(if2id_next_pc), .if2id_valid(if2id_valid)
   );

   initial forever #5 clk = ~clk;

   int ncmp = 0;
   int nmis = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %08h required %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // memory responder: fixed latency or random acks
   int lat = 1;
   bit rmode = 1'b0;
   int rcnt = 0;
   always @(posedge clk) begin
      #1;
      if (imem_req && (rmode ? ($urandom_range(0, 2) != 0) : (rcnt >= lat - 1))) begin
         imem_ack  = 1'b1;
         imem_data = imem_addr ^ KEY;
         rcnt      = 0;
      end else begin
         imem_ack  = 1'b0;
         imem_data = 32'hDEAD_BEEF;
         rcnt      = imem_req ? rcnt + 1 : 0;
      end
   end

   // stream model: which address ID must see next
   logic [31:0] m_exp = RPC;
   logic [31:0] m_tgt = 32'd0;
   bit          m_pend = 1'b0;
   bit          m_owed = 1'b0;
   int          m_idle = 0;
   logic        p_rst = 1'b0, p_stall = 1'b0, p_bt = 1'b0, p_valid = 1'b0;
   logic        p_req = 1'b0, p_ack = 1'b0;
   logic [31:0] p_dest = 32'd0, p_addr = 32'd0, p_instr = 32'd0, p_npc = 32'd0;

   always @(negedge clk) begin
      if (!p_rst) begin
         chk("rst_valid", {31'd0, if2id_valid}, 32'd0);
         chk("rst_instr", if2id_instr, 32'd0);
         chk("rst_next_pc", if2id_next_pc, 32'd0);
         chk("rst_req", {31'd0, imem_req}, 32'd0);
         chk("rst_addr", imem_addr, RPC);
         m_exp  = RPC;
         m_pend = 1'b0;
         m_owed = 1'b0;
         m_idle = 0;
      end else begin
         if (p_bt) begin
            m_tgt = p_dest & 32'hFFFF_FFFC;
            if (!m_pend) begin
               m_pend = 1'b1;
               m_owed = !p_valid;
            end
         end
         if (!if2id_valid)
            chk("bubble_instr", if2id_instr, 32'd0);
         if (p_valid && p_stall) begin
            chk("hold_valid", {31'd0, if2id_valid}, 32'd1);
            chk("hold_instr", if2id_instr, p_instr);
            chk("hold_next_pc", if2id_next_pc, p_npc);
         end else if (if2id_valid) begin
            if (m_pend && !m_owed) begin
               m_exp  = m_tgt;
               m_pend = 1'b0;
            end else if (m_pend) begin
               m_owed = 1'b0;
            end
            $display("word addr=%08h next_pc=%08h instr=%08h", m_exp, if2id_next_pc, if2id_instr);
            chk("word_next_pc", if2id_next_pc, m_exp + 32'd4);
            chk("word_instr", if2id_instr, m_exp ^ KEY);
            m_exp  = m_exp + 32'd4;
            m_idle = 0;
         end else if (!p_stall) begin
            m_idle++;
            if (m_idle == 60) begin
               ncmp++;
               nmis++;
               $display("FAIL liveness: got 60 unstalled cycles without a word, required fewer");
            end
         end
         if (p_req && !p_ack)
            chk("addr_stable", imem_addr, p_addr);
         chk("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
      end
      p_rst = rst;  p_stall = stall;  p_bt = branch_taken;  p_dest = branch_dest;
      p_valid = if2id_valid;  p_instr = if2id_instr;  p_npc = if2id_next_pc;
      p_req = imem_req;  p_ack = imem_ack;  p_addr = imem_addr;
   end

   task automatic wait_valid(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         if (if2id_valid) seen = 1'b1;
         else cyc();
      end
      if (!seen) begin
         ncmp++;
         nmis++;
         $display("FAIL %s: got no valid word in 12 cycles, required one", name);
      end
   endtask

   initial begin
      logic [31:0] hold_npc;
      logic [31:0] inflight;
      int          cnt;
      bit          found;

      repeat (3) cyc();
      chk("reset_req", {31'd0, imem_req}, 32'd0);
      chk("reset_valid", {31'd0, if2id_valid}, 32'd0);

      // back-to-back acks from RESET_PC
      rst = 1'b1;
      cyc();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, RPC);
      cyc();
      chk("first_valid", {31'd0, if2id_valid}, 32'd1);
      chk("first_next_pc", if2id_next_pc, 32'd4);
      chk("first_instr", if2id_instr, KEY);
      cyc();
      chk("second_next_pc", if2id_next_pc, 32'd8);

      // branch while 0x04 sits in ID: 0x08 squashed, target fetched next
      branch_taken = 1'b1;
      branch_dest  = 32'h0000_0103;
      cyc();
      branch_taken = 1'b0;
      chk("br_squash_valid", {31'd0, if2id_valid}, 32'd0);
      chk("br_redirect_addr", imem_addr, 32'h0000_0100);
      cyc();
      chk("br_target_next_pc", if2id_next_pc, 32'h0000_0104);
      chk("br_target_instr", if2id_instr, 32'h0000_0100 ^ KEY);
      cyc();

      // stall mid-stream with ack high
      hold_npc = if2id_next_pc;
      stall = 1'b1;
      cyc();
      chk("stall_req_drop", {31'd0, imem_req}, 32'd0);
      chk("stall_hold_npc", if2id_next_pc, hold_npc);
      repeat (3) cyc();
      chk("stall_hold_npc4", if2id_next_pc, hold_npc);
      stall = 1'b0;
      cyc();
      chk("skid_release", if2id_next_pc, hold_npc + 32'd4);
      cyc();
      chk("after_skid", if2id_next_pc, hold_npc + 32'd8);

      // three-cycle ack latency
      lat = 3;
      repeat (9) cyc();
      cnt = 0;
      repeat (12) begin
         if (if2id_valid) cnt++;
         cyc();
      end
      chk("lat3_rate", cnt, 32'd4);

      // branch while nothing valid and a fetch is outstanding
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (!if2id_valid && imem_req) found = 1'b1;
         else cyc();
      end
      chk("ds_setup", {31'd0, found}, 32'd1);
      inflight     = imem_addr;
      branch_taken = 1'b1;
      branch_dest  = 32'h0000_0200;
      cyc();
      branch_taken = 1'b0;
      wait_valid("ds_wait");
      chk("ds_delay_slot", if2id_next_pc, inflight + 32'd4);
      cyc();
      wait_valid("ds_target_wait");
      chk("ds_target", if2id_next_pc, 32'h0000_0204);

      // second branch while redirect pending: latest target wins
      cyc();
      wait_valid("dbl_wait");
      branch_taken = 1'b1;
      branch_dest  = 32'h0000_0300;
      cyc();
      branch_dest  = 32'h0000_0400;
      cyc();
      branch_taken = 1'b0;
      wait_valid("dbl_target_wait");
      chk("dbl_latest_target", if2id_next_pc, 32'h0000_0404);

      // reset while waiting on memory with stall high
      cyc();
      wait_valid("rstw_wait");
      stall = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      chk("rstw_valid", {31'd0, if2id_valid}, 32'd0);
      chk("rstw_req", {31'd0, imem_req}, 32'd0);
      chk("rstw_addr", imem_addr, RPC);
      rst = 1'b1;
      cyc();
      chk("rstw_restart_req", {31'd0, imem_req}, 32'd1);
      chk("rstw_restart_addr", imem_addr, RPC);
      stall = 1'b0;
      repeat (10) cyc();

      // randomized traffic, including wrap-around targets
      rmode = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         rst   = ($urandom_range(0, 299) != 0);
         if (!branch_taken && !m_pend && $urandom_range(0, 14) == 0) begin
            branch_taken = 1'b1;
            branch_dest  = ($urandom_range(0, 3) == 0) ?
                           (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         end else begin
            branch_taken = 1'b0;
         end
         cyc();
      end
      rst = 1'b1;
      stall = 1'b0;
      branch_taken = 1'b0;
      repeat (20) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end
endmodule
